// File: rtl/axis_throttle_packer.sv
// Decimates a 16-bit ADC sample stream by 2^n and packs kept samples in pairs into 32-bit words behind a small FIFO.
// Optional build macro AXIS_THROTTLE_PACKER_AVERAGE_EN replaces pure decimation with block averaging.
module axis_throttle_packer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        enable,
  input  logic [4:0]  log_throttle,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [15:0] s_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {
    LOW_EMPTY,
    LOW_HELD
  } phase_t;

  logic             enable_d_reg;
  logic             run_reg;
  logic [4:0]       n_reg;
  logic [15:0]      cnt_reg;
  phase_t           phase_reg;
  phase_t           phase_next;
  logic [15:0]      low_reg;
  logic [31:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             overflow_reg;

  logic        rise;
  logic        fall;
  logic [4:0]  n_clamped;
  logic [4:0]  n_eff;
  logic [15:0] keep_mask;
  logic        accept;
  logic        kept;
  logic [15:0] kept_sample;
  logic        push;
  logic [31:0] push_word;
  logic        full;
  logic        pop;
  logic        push_ok;
  logic        drop;

  assign s_axis_tready = 1'b1;

  assign rise      = enable & ~enable_d_reg;
  assign fall      = ~enable & enable_d_reg;
  assign n_clamped = (log_throttle > 5'd16) ? 5'd16 : log_throttle;
  // The rising-edge cycle already accepts a sample, so it must use the freshly latched exponent.
  assign n_eff     = rise ? n_clamped : n_reg;
  assign keep_mask = ~(16'hFFFF << n_eff);
  assign accept    = s_axis_tvalid & enable & (run_reg | rise);
  assign kept      = accept & (cnt_reg == keep_mask);

`ifdef AXIS_THROTTLE_PACKER_AVERAGE_EN
  logic signed [31:0] acc_reg;
  logic signed [31:0] sum;

  assign sum         = acc_reg + $signed({{16{s_axis_tdata[15]}}, s_axis_tdata});
  assign kept_sample = 16'(sum >>> n_eff);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc_reg <= '0;
    end else if (fall) begin
      acc_reg <= '0;
    end else if (accept) begin
      acc_reg <= kept ? '0 : sum;
    end
  end
`else
  assign kept_sample = s_axis_tdata;
`endif

  always_comb begin
    phase_next = phase_reg;
    push       = 1'b0;
    push_word  = {kept_sample, low_reg};
    if (fall) begin
      phase_next = LOW_EMPTY;
    end else if (kept) begin
      case (phase_reg)
        LOW_EMPTY: phase_next = LOW_HELD;
        LOW_HELD: begin
          phase_next = LOW_EMPTY;
          push       = 1'b1;
        end
        default: phase_next = LOW_EMPTY;
      endcase
    end
  end

  assign full    = (count_reg == CNT_W'(FIFO_DEPTH));
  assign pop     = (count_reg != '0) & m_axis_tready;
  // A full FIFO still takes the word when the head leaves on the same edge.
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  always_comb begin
    count_next = count_reg;
    if (push_ok && !pop) begin
      count_next = count_reg + CNT_W'(1);
    end else if (!push_ok && pop) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_word;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      // Starting as "enable seen high" forces a genuine 0->1 edge before capture resumes.
      enable_d_reg <= 1'b1;
      run_reg      <= 1'b0;
      n_reg        <= '0;
      cnt_reg      <= '0;
      phase_reg    <= LOW_EMPTY;
      low_reg      <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      enable_d_reg <= enable;
      if (rise) begin
        run_reg <= 1'b1;
        n_reg   <= n_clamped;
      end else if (!enable) begin
        run_reg <= 1'b0;
      end
      if (fall) begin
        cnt_reg <= '0;
      end else if (accept) begin
        cnt_reg <= kept ? '0 : cnt_reg + 16'd1;
      end
      phase_reg <= phase_next;
      if (kept && phase_reg == LOW_EMPTY) begin
        low_reg <= kept_sample;
      end
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_next;
      if (rise) begin
        overflow_reg <= 1'b0;
      end else if (drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign m_axis_tvalid = (count_reg != '0);
  assign m_axis_tdata  = (count_reg != '0) ? mem[rd_ptr_reg] : 32'd0;
  assign overflow      = overflow_reg;

endmodule
